// File: rtl/uart_receiver_if.sv
// Receive-side UART bundle: serial line in, byte/error strobes and busy out.
// The receiver takes the slave view; the line driver and byte consumer take the master view.
interface uart_receiver_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    output rx,
    input  rx_data,
    input  rx_data_valid,
    input  rx_frame_err,
    input  rx_busy
  );

  modport slave (
    input  rx,
    output rx_data,
    output rx_data_valid,
    output rx_frame_err,
    output rx_busy
  );
endinterface

// File: rtl/uart_receiver.sv
// UART 8N1 receiver, LSB first: rx_sync lags rx by 2 clocks, byte/error strobe lands one cycle after the stop sample.
// No back-pressure: rx_data holds until the next good byte, so the consumer must take it within one frame.
module uart_receiver #(
  parameter int BAUD_VAL = 87
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_receiver_if.slave bus
);
  localparam int          HALF     = (BAUD_VAL - 1) / 2;
  localparam logic [15:0] HALF_CNT = 16'(HALF);
  localparam logic [15:0] LAST_CNT = 16'(BAUD_VAL - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    RXDATA  = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        sync_a, rx_sync;
  logic [1:0]  sync_fill;
  logic        armed;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  data, data_nxt;
  logic        valid, valid_nxt;
  logic        frame_err, frame_err_nxt;

  // The synchroniser resets to 1s, so arming waits until it holds real line samples;
  // otherwise a reset released mid-frame would arm on the reset value and false-start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a    <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync_a    <= bus.rx;
      rx_sync   <= sync_a;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_sync) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    shift_nxt     = shift;
    data_nxt      = data;
    valid_nxt     = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = 16'd0;
        idx_nxt = 3'd0;
        if (armed && !rx_sync) begin
          state_nxt = START;
        end
      end
      START: begin
        if (cnt < HALF_CNT) begin
          cnt_nxt = cnt + 16'd1;
        end else begin
          cnt_nxt   = 16'd0;
          state_nxt = rx_sync ? IDLE : RXDATA;
        end
      end
      RXDATA: begin
        if (cnt < LAST_CNT) begin
          cnt_nxt = cnt + 16'd1;
        end else begin
          cnt_nxt        = 16'd0;
          shift_nxt[idx] = rx_sync;
          if (idx == 3'd7) begin
            idx_nxt   = 3'd0;
            state_nxt = STOP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt < LAST_CNT) begin
          cnt_nxt = cnt + 16'd1;
        end else begin
          cnt_nxt   = 16'd0;
          state_nxt = CLEANUP;
          if (rx_sync) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end
      end
      // A held-low line (break) parks here, so it reports one error rather than a stream of frames.
      CLEANUP: begin
        if (rx_sync) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= 16'd0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shift     <= shift_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  assign bus.rx_data       = data;
  assign bus.rx_data_valid = valid;
  assign bus.rx_frame_err  = frame_err;
  assign bus.rx_busy       = (state != IDLE);

  strobes_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(valid && frame_err));

endmodule
